// File: rtl/collide_sched.sv
// collide_sched: sweeps the lattice one cell at a time through the combinational LBM collider.
// Optional build macro COLLIDE_STATS_EN adds per-sweep density accumulation (i_col_rho / o_rho_sum).
module collide_sched #(
    parameter int NX      = 64,
    parameter int NY      = 32,
    parameter int ADDR_W  = 11,
    parameter int RD_LAT  = 2,
    parameter int COL_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [15:0]       i_omega_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [143:0]      i_mem_rd_data,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [143:0]      o_mem_wr_data,
    input  logic              i_mem_wr_ready,
    output logic [15:0]       o_col_omega,
    output logic [143:0]      o_col_f,
    input  logic [143:0]      i_col_f_new
`ifdef COLLIDE_STATS_EN
    ,
    input  logic [15:0]       i_col_rho,
    output logic [31:0]       o_rho_sum
`endif
);

    localparam int CELLS   = NX * NY;
    localparam int MAX_LAT = (RD_LAT > COL_LAT) ? RD_LAT : COL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  COL_LAST  = CNT_W'(COL_LAT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WAIT_RD = 3'd2;
    localparam logic [2:0] S_COLLIDE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic              r_wr_en;
    logic [143:0]      r_wr_data;
    logic [15:0]       r_omega;
    logic [143:0]      r_col_f;

    logic [2:0] w_state_nxt;
    logic       w_start_acc;
    logic       w_rd_cap;
    logic       w_col_cap;
    logic       w_wr_acc;

    // Next-state decode plus the one-cycle event strobes that steer the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_rd_cap    = 1'b0;
        w_col_cap   = 1'b0;
        w_wr_acc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_READ;
                    w_start_acc = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                w_state_nxt = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (r_cnt == RD_LAST) begin
                    w_state_nxt = S_COLLIDE;
                    w_rd_cap    = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT_RD;
                end
            end
            S_COLLIDE: begin
                if (r_cnt == COL_LAST) begin
                    w_state_nxt = S_WRITE;
                    w_col_cap   = 1'b1;
                end else begin
                    w_state_nxt = S_COLLIDE;
                end
            end
            S_WRITE: begin
                if (i_mem_wr_ready) begin
                    w_wr_acc = 1'b1;
                    if (r_addr == LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, cell index and the shared latency/settle counter (restarts on every state change).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_addr  <= {ADDR_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if ((r_state == S_WAIT_RD) || (r_state == S_COLLIDE)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= {CNT_W{1'b0}};
            end
            if (w_start_acc) begin
                r_addr <= {ADDR_W{1'b0}};
            end else if (w_wr_acc) begin
                r_addr <= (r_addr == LAST_ADDR) ? {ADDR_W{1'b0}} : (r_addr + ADDR_W'(1));
            end else begin
                r_addr <= r_addr;
            end
        end
    end

    // Control outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done  <= (w_state_nxt == S_DONE);
            r_rd_en <= (w_state_nxt == S_READ);
            r_wr_en <= (w_state_nxt == S_WRITE);
        end
    end

    // Datapath captures; each register only moves on its own event and holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_omega   <= 16'h0000;
            r_col_f   <= 144'd0;
            r_wr_data <= 144'd0;
        end else begin
            if (w_start_acc) begin
                r_omega <= i_omega_in;
            end else begin
                r_omega <= r_omega;
            end
            if (w_rd_cap) begin
                r_col_f <= i_mem_rd_data;
            end else begin
                r_col_f <= r_col_f;
            end
            if (w_col_cap) begin
                r_wr_data <= i_col_f_new;
            end else begin
                r_wr_data <= r_wr_data;
            end
        end
    end

`ifdef COLLIDE_STATS_EN
    logic [31:0] r_rho_acc;
    logic [31:0] r_rho_sum;

    // Density accumulator; the published sum becomes valid in the DONE cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rho_acc <= 32'h0000_0000;
            r_rho_sum <= 32'h0000_0000;
        end else begin
            if (w_start_acc) begin
                r_rho_acc <= 32'h0000_0000;
            end else if (w_col_cap) begin
                r_rho_acc <= r_rho_acc + {{16{i_col_rho[15]}}, i_col_rho};
            end else begin
                r_rho_acc <= r_rho_acc;
            end
            if (w_state_nxt == S_DONE) begin
                r_rho_sum <= r_rho_acc;
            end else begin
                r_rho_sum <= r_rho_sum;
            end
        end
    end

    assign o_rho_sum = r_rho_sum;
`endif

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_mem_rd_en   = r_rd_en;
    assign o_mem_rd_addr = r_addr;
    assign o_mem_wr_en   = r_wr_en;
    assign o_mem_wr_addr = r_addr;
    assign o_mem_wr_data = r_wr_data;
    assign o_col_omega   = r_omega;
    assign o_col_f       = r_col_f;

endmodule

// File: tb/tb_collide_sched.sv
// Directed bench for collide_sched on a 4x2 lattice with a behavioural RAM and collider mock.
module tb_collide_sched;

    localparam int NX      = 4;
    localparam int NY      = 2;
    localparam int ADDR_W  = 3;
    localparam int RD_LAT  = 2;
    localparam int COL_LAT = 1;
    localparam int CELLS   = NX * NY;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [15:0]       omega_in;
    logic              busy, done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [143:0]      rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [143:0]      wr_data;
    logic              wr_ready;
    logic [15:0]       col_omega;
    logic [143:0]      col_f;
    logic [143:0]      col_f_new;
    logic [15:0]       col_rho;
    logic [31:0]       rho_sum;
    logic              add_one;

    int n_chk = 0;
    int n_err = 0;

    logic [143:0] mem     [CELLS];
    logic [143:0] rd_pipe [RD_LAT];

    always #5 clk = ~clk;

    collide_sched #(.NX(NX), .NY(NY), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .COL_LAT(COL_LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_omega_in(omega_in),
        .o_busy(busy), .o_done(done),
        .o_mem_rd_en(rd_en), .o_mem_rd_addr(rd_addr), .i_mem_rd_data(rd_data),
        .o_mem_wr_en(wr_en), .o_mem_wr_addr(wr_addr), .o_mem_wr_data(wr_data),
        .i_mem_wr_ready(wr_ready),
        .o_col_omega(col_omega), .o_col_f(col_f),
`ifdef COLLIDE_STATS_EN
        .i_col_rho(col_rho), .o_rho_sum(rho_sum),
`endif
        .i_col_f_new(col_f_new)
    );

`ifndef COLLIDE_STATS_EN
    assign rho_sum = 32'h0000_0000;
`endif

    // RAM model: data for an address appears RD_LAT cycles after it is presented.
    always_ff @(posedge clk) begin
        rd_pipe[0] <= mem[rd_addr];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    // Collider mock: identity, or +1 on every 16-bit lane.
    always_comb begin
        col_f_new = col_f;
        if (add_one) begin
            for (int l = 0; l < 9; l++) col_f_new[16*l +: 16] = col_f[16*l +: 16] + 16'h0001;
        end
    end

    function automatic logic [143:0] lanes_inc(input logic [143:0] w);
        logic [143:0] r;
        for (int l = 0; l < 9; l++) r[16*l +: 16] = w[16*l +: 16] + 16'h0001;
        return r;
    endfunction

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        add_one;
        int          stall_cell;
        int          stall_len;
        logic [15:0] omega;
        logic        disturb;
        logic [15:0] rho;
        int          exp_done;
        logic [31:0] exp_rho;
    } vec_t;

    vec_t tbl [4];

    task automatic run_sweep(input int v, input vec_t tv);
        int done_cyc = -1, done_cnt = 0;
        int busy_first = -1, busy_last = -1, busy_cnt = 0;
        int om_bad = 0, wr_n = 0, rd_n = 0;
        int stall_left = tv.stall_len, hold_cnt = 0, hold_bad = 0;
        logic [143:0] hold_data = 144'd0;
        logic [ADDR_W-1:0] wa_log [16];
        logic [143:0]      wd_log [16];
        logic [ADDR_W-1:0] ra_log [16];
        logic [143:0] exp_w;

        for (int k = 0; k < CELLS; k++)
            mem[k] = {{4{16'h00E4}}, {4{16'h038E}}, 16'h0E39 + 16'(k) + 16'(v * 32)};
        add_one  = tv.add_one;
        col_rho  = tv.rho;
        omega_in = tv.omega;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        for (int t = 1; t < 150; t++) begin
            @(posedge clk); #1;
            if (tv.disturb && t == 10) omega_in = 16'h0000;
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = t;
                busy_last = t;
            end
            if (col_omega !== tv.omega) om_bad++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = t;
`ifdef COLLIDE_STATS_EN
                    chk($sformatf("v%0d rho_sum", v), 144'(rho_sum), 144'(tv.exp_rho));
`endif
                end
            end
            start = tv.disturb && ((t >= 10 && t <= 12) || (done && done_cyc == t));
            if (rd_en && rd_n < 16) begin
                ra_log[rd_n] = rd_addr;
                rd_n++;
            end
            if (wr_en) begin
                if (int'(wr_addr) == tv.stall_cell) begin
                    hold_cnt++;
                    if (hold_cnt == 1) hold_data = wr_data;
                    else if (wr_data !== hold_data) hold_bad++;
                end
                wr_ready = !(int'(wr_addr) == tv.stall_cell && stall_left > 0);
                if (!wr_ready) stall_left--;
                if (wr_ready && wr_n < 16) begin
                    wa_log[wr_n] = wr_addr;
                    wd_log[wr_n] = wr_data;
                    wr_n++;
                end
            end else begin
                wr_ready = 1'b1;
            end
            if (done_cyc >= 0 && t >= done_cyc + 3) break;
        end
        start = 1'b0;

        if (done_cyc < 0) $display("FAIL v%0d timeout: no done within budget", v);
        chk($sformatf("v%0d done_cycle", v), 144'(done_cyc), 144'(tv.exp_done));
        chk($sformatf("v%0d done_pulses", v), 144'(done_cnt), 144'd1);
        chk($sformatf("v%0d busy_first", v), 144'(busy_first), 144'd1);
        chk($sformatf("v%0d busy_last", v), 144'(busy_last), 144'(tv.exp_done - 1));
        chk($sformatf("v%0d busy_cycles", v), 144'(busy_cnt), 144'(tv.exp_done - 1));
        chk($sformatf("v%0d omega_bad_cycles", v), 144'(om_bad), 144'd0);
        chk($sformatf("v%0d writes", v), 144'(wr_n), 144'(CELLS));
        chk($sformatf("v%0d reads", v), 144'(rd_n), 144'(CELLS));
        for (int k = 0; k < CELLS && k < wr_n && k < rd_n; k++) begin
            exp_w = tv.add_one ? lanes_inc(mem[k]) : mem[k];
            chk($sformatf("v%0d rd_addr[%0d]", v, k), 144'(ra_log[k]), 144'(k));
            chk($sformatf("v%0d wr_addr[%0d]", v, k), 144'(wa_log[k]), 144'(ra_log[k]));
            chk($sformatf("v%0d wr_data[%0d]", v, k), wd_log[k], exp_w);
        end
        if (v == 0 && wr_n > 0)
            chk("v0 cell0 packed", wd_log[0], 144'h00E4_00E4_00E4_00E4_038E_038E_038E_038E_0E39);
        if (tv.stall_cell >= 0) begin
            chk($sformatf("v%0d stall_hold_cycles", v), 144'(hold_cnt), 144'(tv.stall_len + 1));
            chk($sformatf("v%0d stall_data_stable", v), 144'(hold_bad), 144'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 144'(busy), 144'd0);
        chk({tag, " done"}, 144'(done), 144'd0);
        chk({tag, " rd_en"}, 144'(rd_en), 144'd0);
        chk({tag, " rd_addr"}, 144'(rd_addr), 144'd0);
        chk({tag, " wr_en"}, 144'(wr_en), 144'd0);
        chk({tag, " wr_addr"}, 144'(wr_addr), 144'd0);
        chk({tag, " wr_data"}, wr_data, 144'd0);
        chk({tag, " col_omega"}, 144'(col_omega), 144'd0);
        chk({tag, " col_f"}, col_f, 144'd0);
        chk({tag, " rho_sum"}, 144'(rho_sum), 144'd0);
    endtask

    initial begin
        int seen_wr, late_wr, late_busy;
        tbl[0] = '{1'b0, -1, 0, 16'h1000, 1'b0, 16'h2000, 41, 32'h0001_0000};
        tbl[1] = '{1'b1, -1, 0, 16'h0800, 1'b0, 16'hE000, 41, 32'hFFFF_0000};
        tbl[2] = '{1'b0,  2, 3, 16'h2000, 1'b0, 16'h0001, 44, 32'h0000_0008};
        tbl[3] = '{1'b1,  5, 1, 16'h1800, 1'b1, 16'h0000, 42, 32'h0000_0000};

        rst = 1'b1; start = 1'b0; omega_in = 16'h0000; wr_ready = 1'b1;
        add_one = 1'b0; col_rho = 16'h0000;
        for (int k = 0; k < CELLS; k++) mem[k] = 144'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 4; v++) run_sweep(v, tbl[v]);

        // Reset while a write is stalled, then make sure nothing resumes.
        omega_in = 16'h1234; wr_ready = 1'b0; add_one = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        seen_wr = 0;
        for (int t = 0; t < 50 && seen_wr == 0; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (wr_en) seen_wr = 1;
        end
        chk("rst_seq reached WRITE", 144'(seen_wr), 144'd1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("mid_write_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        wr_ready = 1'b1;
        late_wr = 0; late_busy = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (wr_en) late_wr++;
            if (busy) late_busy++;
        end
        chk("post_rst writes", 144'(late_wr), 144'd0);
        chk("post_rst busy", 144'(late_busy), 144'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
